motor_pwm_drive: RTL

Consumes the slow square-wave output of the motor clock divider and drives one H-bridge channel. It accepts speed/direction commands over a valid/ready handshake and generates a PWM pair whose duty slews toward the commanded value once per divider tick. Every direction reversal passes through a mandatory ramp-to-zero and a dead-time interval. It sits between the motor command logic and the H-bridge output pins.

---
 rtl/motor_pwm_drive.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/motor_pwm_drive.sv
// H-bridge PWM drive: slews duty toward a commanded target once per divider tick and
// forces ramp-to-zero plus dead time on every reversal. Define MOTOR_RAMP_EN for slew limiting.
module motor_pwm_drive #(
    parameter int PWM_BITS   = 8,
    parameter int RAMP_STEP  = 4,
    parameter int DEAD_TICKS = 16
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clk_div,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [PWM_BITS-1:0] cmd_duty,
    output logic                pwm_a,
    output logic                pwm_b,
    output logic [PWM_BITS-1:0] cur_duty,
    output logic                busy
);

    localparam int DW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_TICKS - 1);

`ifdef MOTOR_RAMP_EN
    localparam int STEP_EFF = RAMP_STEP;
`else
    // A step as large as the full duty range reaches any target in a single tick.
    localparam int STEP_EFF = (2 ** PWM_BITS - 1) + 0 * RAMP_STEP;
`endif

    localparam logic signed [PWM_BITS:0] STEP_S = (PWM_BITS + 1)'(STEP_EFF);
    localparam logic [PWM_BITS-1:0]      STEP_U = PWM_BITS'(STEP_EFF);

    typedef enum logic [1:0] {IDLE, RUN, DECEL, DEAD} state_t;

    state_t                state;
    logic                  clk_div_q;
    logic                  cur_dir;
    logic [PWM_BITS-1:0]   tgt_duty;
    logic                  tgt_dir;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [DW-1:0]         dead_cnt;

    logic                  tick;
    logic                  accept;
    logic                  pwm_on;
    logic [PWM_BITS-1:0]   run_next;
    logic [PWM_BITS-1:0]   decel_next;

    // Moves cur_in at most one step toward tgt_in and lands on tgt_in exactly.
    function automatic logic [PWM_BITS-1:0] ramp_toward(
        input logic [PWM_BITS-1:0] cur_in,
        input logic [PWM_BITS-1:0] tgt_in
    );
        logic signed [PWM_BITS:0] diff;
        diff = $signed({1'b0, tgt_in}) - $signed({1'b0, cur_in});
        if (diff > STEP_S)
            ramp_toward = cur_in + STEP_U;
        else if (diff < -STEP_S)
            ramp_toward = cur_in - STEP_U;
        else
            ramp_toward = tgt_in;
    endfunction

    assign tick       = clk_div & ~clk_div_q;
    assign cmd_ready  = (state == IDLE) || (state == RUN);
    assign accept     = cmd_valid & cmd_ready;
    assign pwm_on     = pwm_cnt < cur_duty;
    assign run_next   = tick ? ramp_toward(cur_duty, tgt_duty) : cur_duty;
    assign decel_next = ramp_toward(cur_duty, '0);
    assign busy       = (state == DECEL) || (state == DEAD) || (cur_duty != tgt_duty);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= IDLE;
            clk_div_q <= 1'b1;
            cur_duty  <= '0;
            cur_dir   <= 1'b1;
            tgt_duty  <= '0;
            tgt_dir   <= 1'b1;
            pwm_cnt   <= '0;
            dead_cnt  <= '0;
            pwm_a     <= 1'b0;
            pwm_b     <= 1'b0;
        end else begin
            clk_div_q <= clk_div;
            pwm_cnt   <= pwm_cnt + 1'b1;
            pwm_a     <= pwm_on & cur_dir & (state != DEAD);
            pwm_b     <= pwm_on & ~cur_dir & (state != DEAD);

            if (accept) begin
                tgt_duty <= cmd_duty;
                tgt_dir  <= cmd_dir;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cmd_dir != cur_dir) begin
                            state    <= DEAD;
                            dead_cnt <= '0;
                        end else if (cmd_duty != '0) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    cur_duty <= run_next;
                    // Reversal decision uses the duty after this cycle's step so a
                    // non-zero duty can never be carried into the dead interval.
                    if (accept && (cmd_dir != cur_dir)) begin
                        if (run_next != '0) begin
                            state <= DECEL;
                        end else begin
                            state    <= DEAD;
                            dead_cnt <= '0;
                        end
                    end else if (!accept && (cur_duty == '0) && (tgt_duty == '0)) begin
                        state <= IDLE;
                    end
                end
                DECEL: begin
                    if (cur_duty == '0) begin
                        state    <= DEAD;
                        dead_cnt <= '0;
                    end else if (tick) begin
                        cur_duty <= decel_next;
                        if (decel_next == '0) begin
                            state    <= DEAD;
                            dead_cnt <= '0;
                        end
                    end
                end
                DEAD: begin
                    if (tick) begin
                        if (dead_cnt == DEAD_LAST) begin
                            cur_dir <= tgt_dir;
                            state   <= (tgt_duty != '0) ? RUN : IDLE;
                        end else begin
                            dead_cnt <= dead_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
